mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter sharing the single BRAM memory port (separate read-address and write-address/data/strobe buses, synchronous read data) between the RISC-V core and a second requester such as a debug loader or DMA.
- Sits between the requesters and bram_memory, in the divided-clock domain.
- Grants one transaction at a time, round-robin, with valid/ready request handshakes and a read-response strobe.

Parameters:
- pReadLatency, 1, cycles from the slave read address being driven to iwSReadData being valid (1..7).
- pAddrWidth, 32, address width of masters and slave.

Ports:
- iwClk  input  1  system clock; all logic on the rising edge.
- iwRst  input  1  synchronous, active-high reset.
- iwM0Valid  input  1  master 0 request valid.
- iwM0Write  input  1  master 0: 1 = write, 0 = read.
- iwM0Addr  input  pAddrWidth  master 0 byte address.
- iwM0WData  input  32  master 0 write data.
- iwM0Wstrb  input  4  master 0 byte strobes.
- owM0Ready  output  1  one-cycle pulse when the master 0 request is accepted.
- owM0RValid  output  1  one-cycle pulse when the master 0 read data is valid.
- owM0RData  output  32  master 0 read data, held until the next response.
- iwM1Valid, iwM1Write, iwM1Addr, iwM1WData, iwM1Wstrb, owM1Ready, owM1RValid, owM1RData: same as master 0, for master 1.
- owSReadAddr  output  pAddrWidth  to slave read address.
- owSWriteAddr  output  pAddrWidth  to slave write address.
- owSWriteData  output  32  to slave write data.
- owSWstrb  output  4  to slave write strobes; 0 means no write.
- iwSReadData  input  32  from slave read data.

Behaviour:
- Reset (synchronous, iwRst=1 at a rising edge):
  - State becomes IDLE and the priority pointer points to M0.
  - All outputs are 0, including owSReadAddr, owSWriteAddr, owSWriteData, owSWstrb, both RData buses, and all Ready/RValid pulses.
- All outputs are registered.
- Masters must hold Valid, Write, Addr, WData and Wstrb stable from assertion until they see Ready. Valid must not drop before Ready.
- States: IDLE, GRANT, RWAIT, RDONE.
- IDLE:
  - No Valid: stay in IDLE.
  - One Valid: that master wins.
  - Both Valid: the master indicated by the priority pointer wins, then the pointer moves to the other master.
  - With a winner, latch the winner's id, Write, Addr, WData and Wstrb, then go to GRANT.
- GRANT (exactly 1 cycle):
  - The winner's Ready pulses high.
  - Write: owSWriteAddr/owSWriteData = latched values and owSWstrb = latched strobes for this cycle only, then IDLE.
  - Read: owSReadAddr = latched address, then RWAIT.
- RWAIT:
  - owSReadAddr is held.
  - A counter runs from 1 up to pReadLatency; when the count is reached, go to RDONE.
  - With pReadLatency=1, RWAIT lasts 1 cycle.
- RDONE (1 cycle):
  - The winner's RData ← iwSReadData and RValid pulses.
  - Return to IDLE.
- Throughput:
  - Write: request seen in IDLE to Ready = 1 cycle; 2 cycles per write.
  - Read: RValid is 2+pReadLatency cycles after the request is first sampled in IDLE; 3+pReadLatency cycles per read.
- owSWstrb is 0 in every state except a write GRANT. A write with Wstrb=0 is still accepted (Ready pulses) but modifies nothing.
- owSWriteAddr/owSWriteData hold their last values outside a write GRANT. owSReadAddr holds its last value outside reads.
- A request arriving in any state other than IDLE waits. It is sampled again when the FSM returns to IDLE; no request is dropped.
- Fairness: under continuous requests from both masters, grants alternate M0, M1, M0, … with no starvation.
- iwRst asserted mid-transaction (GRANT/RWAIT/RDONE):
  - The transaction is abandoned with no Ready/RValid pulse afterwards.
  - owSWstrb is 0 on the next cycle.
  - The FSM is in IDLE.
- The address is passed through unmodified; word alignment is the slave's responsibility.

Test Plan:
- Reset, then M0 write 0x0000_0010 ← 0xDEAD_BEEF with Wstrb 0xF -> owSWstrb=0xF for exactly 1 cycle with the matching addr/data; owM0Ready pulses in the same cycle; a readback by M0 returns owM0RData=0xDEAD_BEEF with owM0RValid 3 cycles after the request is sampled (pReadLatency=1).
- M0 and M1 assert reads in the same cycle after reset -> M0 granted first, then M1; each RValid goes only to its own master and RData to the correct bus.
- Both masters hold continuous writes for 8 grants -> Ready order M0,M1,M0,M1,…; 4 grants each.
- M1 byte write Wstrb=0x2, data 0x0000_AB00, to a word holding 0x1122_3344 -> readback 0x1122_AB44; a write with Wstrb=0 -> Ready pulses and memory is unchanged.
- pReadLatency=3 build: M1 read -> owSReadAddr held 3 RWAIT cycles; RValid 5 cycles after the request is sampled.
- iwRst raised in RWAIT of an M0 read -> no owM0RValid; all outputs 0 next cycle; after release, a new M1 request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets two requesters (the RISC-V core
// and a DMA/debug loader) share the single port of bram_memory. One
// transaction is in flight at a time. Every output is a register.
module mem_arbiter #(
   parameter int pReadLatency = 1,
   parameter int pAddrWidth   = 32
) (
   input  logic                  iwClk,
   input  logic                  iwRst,
   input  logic                  iwM0Valid,
   input  logic                  iwM0Write,
   input  logic [pAddrWidth-1:0] iwM0Addr,
   input  logic [31:0]           iwM0WData,
   input  logic [3:0]            iwM0Wstrb,
   output logic                  owM0Ready,
   output logic                  owM0RValid,
   output logic [31:0]           owM0RData,
   input  logic                  iwM1Valid,
   input  logic                  iwM1Write,
   input  logic [pAddrWidth-1:0] iwM1Addr,
   input  logic [31:0]           iwM1WData,
   input  logic [3:0]            iwM1Wstrb,
   output logic                  owM1Ready,
   output logic                  owM1RValid,
   output logic [31:0]           owM1RData,
   output logic [pAddrWidth-1:0] owSReadAddr,
   output logic [pAddrWidth-1:0] owSWriteAddr,
   output logic [31:0]           owSWriteData,
   output logic [3:0]            owSWstrb,
   input  logic [31:0]           iwSReadData
);

   typedef enum logic [1:0] {IDLE, GRANT, RWAIT, RDONE} state_t;

   localparam logic [2:0] cLatency = 3'(pReadLatency);

   state_t                state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic                  winner_q, winner_d;
   logic                  write_q, write_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  m0Ready_q, m0Ready_d;
   logic                  m1Ready_q, m1Ready_d;
   logic                  m0RValid_q, m0RValid_d;
   logic                  m1RValid_q, m1RValid_d;
   logic [31:0]           m0RData_q, m0RData_d;
   logic [31:0]           m1RData_q, m1RData_d;
   logic [pAddrWidth-1:0] sReadAddr_q, sReadAddr_d;
   logic [pAddrWidth-1:0] sWriteAddr_q, sWriteAddr_d;
   logic [31:0]           sWriteData_q, sWriteData_d;
   logic [3:0]            sWstrb_q, sWstrb_d;

   logic                  pick1;
   logic                  selWrite;
   logic [pAddrWidth-1:0] selAddr;
   logic [31:0]           selWData;
   logic [3:0]            selWstrb;

   // Pick the candidate winner: a lone requester wins, a tie goes to ptr_q.
   always_comb begin
      pick1    = iwM1Valid && (!iwM0Valid || ptr_q);
      selWrite = pick1 ? iwM1Write : iwM0Write;
      selAddr  = pick1 ? iwM1Addr  : iwM0Addr;
      selWData = pick1 ? iwM1WData : iwM0WData;
      selWstrb = pick1 ? iwM1Wstrb : iwM0Wstrb;
   end

   // Next-state logic. Output registers are loaded on the same edge that
   // enters a state, so they hold the request's address, data and strobes.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      winner_d     = winner_q;
      write_d      = write_q;
      cnt_d        = cnt_q;
      m0Ready_d    = 1'b0;
      m1Ready_d    = 1'b0;
      m0RValid_d   = 1'b0;
      m1RValid_d   = 1'b0;
      m0RData_d    = m0RData_q;
      m1RData_d    = m1RData_q;
      sReadAddr_d  = sReadAddr_q;
      sWriteAddr_d = sWriteAddr_q;
      sWriteData_d = sWriteData_q;
      sWstrb_d     = 4'h0;
      case (state_q)
         IDLE: begin
            if (iwM0Valid || iwM1Valid) begin
               state_d   = GRANT;
               winner_d  = pick1;
               write_d   = selWrite;
               m0Ready_d = !pick1;
               m1Ready_d = pick1;
               if (iwM0Valid && iwM1Valid) begin
                  ptr_d = !pick1;
               end
               if (selWrite) begin
                  sWriteAddr_d = selAddr;
                  sWriteData_d = selWData;
                  sWstrb_d     = selWstrb;
               end else begin
                  sReadAddr_d = selAddr;
               end
            end
         end
         GRANT: begin
            if (write_q) begin
               state_d = IDLE;
            end else begin
               state_d = RWAIT;
               cnt_d   = 3'd1;
            end
         end
         RWAIT: begin
            if (cnt_q == cLatency) begin
               state_d = RDONE;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         RDONE: begin
            state_d = IDLE;
            if (winner_q) begin
               m1RData_d  = iwSReadData;
               m1RValid_d = 1'b1;
            end else begin
               m0RData_d  = iwSReadData;
               m0RValid_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge iwClk) begin
      if (iwRst) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         winner_q     <= 1'b0;
         write_q      <= 1'b0;
         cnt_q        <= 3'd0;
         m0Ready_q    <= 1'b0;
         m1Ready_q    <= 1'b0;
         m0RValid_q   <= 1'b0;
         m1RValid_q   <= 1'b0;
         m0RData_q    <= 32'h0;
         m1RData_q    <= 32'h0;
         sReadAddr_q  <= '0;
         sWriteAddr_q <= '0;
         sWriteData_q <= 32'h0;
         sWstrb_q     <= 4'h0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         winner_q     <= winner_d;
         write_q      <= write_d;
         cnt_q        <= cnt_d;
         m0Ready_q    <= m0Ready_d;
         m1Ready_q    <= m1Ready_d;
         m0RValid_q   <= m0RValid_d;
         m1RValid_q   <= m1RValid_d;
         m0RData_q    <= m0RData_d;
         m1RData_q    <= m1RData_d;
         sReadAddr_q  <= sReadAddr_d;
         sWriteAddr_q <= sWriteAddr_d;
         sWriteData_q <= sWriteData_d;
         sWstrb_q     <= sWstrb_d;
      end
   end

   assign owM0Ready    = m0Ready_q;
   assign owM1Ready    = m1Ready_q;
   assign owM0RValid   = m0RValid_q;
   assign owM1RValid   = m1RValid_q;
   assign owM0RData    = m0RData_q;
   assign owM1RData    = m1RData_q;
   assign owSReadAddr  = sReadAddr_q;
   assign owSWriteAddr = sWriteAddr_q;
   assign owSWriteData = sWriteData_q;
   assign owSWstrb     = sWstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives two arbiter instances (read latency 1 and 3), each
// backed by a small behavioural memory, and compares against hand-derived
// expectations.
module tb_mem_arbiter;

   typedef struct {
      string       name;
      bit          master;
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] expRData;
   } vec_t;

   logic clk;
   logic iwRst;

   // Instance A: read latency 1
   logic        aM0Valid, aM0Write, aM1Valid, aM1Write;
   logic [31:0] aM0Addr, aM0WData, aM1Addr, aM1WData;
   logic [3:0]  aM0Wstrb, aM1Wstrb;
   logic        aM0Ready, aM0RValid, aM1Ready, aM1RValid;
   logic [31:0] aM0RData, aM1RData;
   logic [31:0] aSReadAddr, aSWriteAddr, aSWriteData, aSReadData;
   logic [3:0]  aSWstrb;

   // Instance B: read latency 3
   logic        bM0Valid, bM0Write, bM1Valid, bM1Write;
   logic [31:0] bM0Addr, bM0WData, bM1Addr, bM1WData;
   logic [3:0]  bM0Wstrb, bM1Wstrb;
   logic        bM0Ready, bM0RValid, bM1Ready, bM1RValid;
   logic [31:0] bM0RData, bM1RData;
   logic [31:0] bSReadAddr, bSWriteAddr, bSWriteData, bSReadData;
   logic [3:0]  bSWstrb;

   logic [31:0] memA [0:15] = '{5: 32'h1122_3344, 6: 32'h5555_AAAA, default: 32'h0};
   logic [31:0] bPipe [0:2] = '{default: 32'h0};
   logic [31:0] expRData [2];

   int testsRun  = 0;
   int failCount = 0;

   mem_arbiter #(.pReadLatency(1), .pAddrWidth(32)) dutA (
      .iwClk(clk), .iwRst(iwRst),
      .iwM0Valid(aM0Valid), .iwM0Write(aM0Write), .iwM0Addr(aM0Addr),
      .iwM0WData(aM0WData), .iwM0Wstrb(aM0Wstrb),
      .owM0Ready(aM0Ready), .owM0RValid(aM0RValid), .owM0RData(aM0RData),
      .iwM1Valid(aM1Valid), .iwM1Write(aM1Write), .iwM1Addr(aM1Addr),
      .iwM1WData(aM1WData), .iwM1Wstrb(aM1Wstrb),
      .owM1Ready(aM1Ready), .owM1RValid(aM1RValid), .owM1RData(aM1RData),
      .owSReadAddr(aSReadAddr), .owSWriteAddr(aSWriteAddr),
      .owSWriteData(aSWriteData), .owSWstrb(aSWstrb), .iwSReadData(aSReadData)
   );

   mem_arbiter #(.pReadLatency(3), .pAddrWidth(32)) dutB (
      .iwClk(clk), .iwRst(iwRst),
      .iwM0Valid(bM0Valid), .iwM0Write(bM0Write), .iwM0Addr(bM0Addr),
      .iwM0WData(bM0WData), .iwM0Wstrb(bM0Wstrb),
      .owM0Ready(bM0Ready), .owM0RValid(bM0RValid), .owM0RData(bM0RData),
      .iwM1Valid(bM1Valid), .iwM1Write(bM1Write), .iwM1Addr(bM1Addr),
      .iwM1WData(bM1WData), .iwM1Wstrb(bM1Wstrb),
      .owM1Ready(bM1Ready), .owM1RValid(bM1RValid), .owM1RData(bM1RData),
      .owSReadAddr(bSReadAddr), .owSWriteAddr(bSWriteAddr),
      .owSWriteData(bSWriteData), .owSWstrb(bSWstrb), .iwSReadData(bSReadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural BRAM for A: byte-strobed write, one-cycle synchronous read
   always @(posedge clk) begin
      if (aSWstrb[0]) memA[aSWriteAddr[5:2]][7:0]   <= aSWriteData[7:0];
      if (aSWstrb[1]) memA[aSWriteAddr[5:2]][15:8]  <= aSWriteData[15:8];
      if (aSWstrb[2]) memA[aSWriteAddr[5:2]][23:16] <= aSWriteData[23:16];
      if (aSWstrb[3]) memA[aSWriteAddr[5:2]][31:24] <= aSWriteData[31:24];
      aSReadData <= memA[aSReadAddr[5:2]];
   end

   // Three-stage read pipeline for B returning a pattern derived from the address
   always @(posedge clk) begin
      bPipe[0] <= {bSReadAddr[15:0], 16'hC0DE};
      bPipe[1] <= bPipe[0];
      bPipe[2] <= bPipe[1];
   end
   assign bSReadData = bPipe[2];

   task automatic checkOutput(input string name, input logic [199:0] actual,
                              input logic [199:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkAllZero(input string name);
      checkOutput(name, {aM0Ready, aM0RValid, aM0RData, aM1Ready, aM1RValid, aM1RData,
                         aSReadAddr, aSWriteAddr, aSWriteData, aSWstrb}, '0);
   endtask

   task automatic driveMaster(input bit m, input logic v, input logic w,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      if (m) begin
         aM1Valid = v; aM1Write = w; aM1Addr = addr; aM1WData = data; aM1Wstrb = strb;
      end else begin
         aM0Valid = v; aM0Write = w; aM0Addr = addr; aM0WData = data; aM0Wstrb = strb;
      end
   endtask

   task automatic resetDut();
      iwRst = 1'b1;
      repeat (2) @(negedge clk);
      checkAllZero("reset outputs");
      iwRst = 1'b0;
      expRData[0] = 32'h0;
      expRData[1] = 32'h0;
   endtask

   // One full transaction on A from the IDLE cycle back to the next IDLE cycle
   task automatic applyStimulus(input vec_t v);
      driveMaster(v.master, 1'b1, v.write, v.addr, v.wdata, v.wstrb);
      @(negedge clk);
      checkOutput({v.name, " ready"}, {aM1Ready, aM0Ready}, v.master ? 2'b10 : 2'b01);
      if (v.write) begin
         checkOutput({v.name, " wstrb"}, aSWstrb, v.wstrb);
         checkOutput({v.name, " waddr"}, aSWriteAddr, v.addr);
         checkOutput({v.name, " wdata"}, aSWriteData, v.wdata);
      end else begin
         checkOutput({v.name, " raddr"}, aSReadAddr, v.addr);
      end
      driveMaster(v.master, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (v.write) begin
         @(negedge clk);
         checkOutput({v.name, " wstrb cleared"}, aSWstrb, 4'h0);
         checkOutput({v.name, " ready dropped"}, {aM1Ready, aM0Ready}, 2'b00);
      end else begin
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput({v.name, " rvalid early"}, {aM1RValid, aM0RValid}, 2'b00);
         end
         @(negedge clk);
         expRData[v.master] = v.expRData;
         checkOutput({v.name, " rvalid"}, {aM1RValid, aM0RValid}, v.master ? 2'b10 : 2'b01);
         checkOutput({v.name, " m0 rdata"}, aM0RData, expRData[0]);
         checkOutput({v.name, " m1 rdata"}, aM1RData, expRData[1]);
      end
   endtask

   initial begin
      vec_t vecs [8];
      int   m0Grants;
      int   m1Grants;
      logic [1:0] expReady;

      vecs[0] = '{"m0 wr 0x10",   1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0};
      vecs[1] = '{"m0 rd 0x10",   1'b0, 1'b0, 32'h10, 32'h0,         4'h0, 32'hDEAD_BEEF};
      vecs[2] = '{"m1 byte wr",   1'b1, 1'b1, 32'h14, 32'h0000_AB00, 4'h2, 32'h0};
      vecs[3] = '{"m1 rd 0x14",   1'b1, 1'b0, 32'h14, 32'h0,         4'h0, 32'h1122_AB44};
      vecs[4] = '{"m0 wr strb0",  1'b0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'h0, 32'h0};
      vecs[5] = '{"m0 rd 0x14",   1'b0, 1'b0, 32'h14, 32'h0,         4'h0, 32'h1122_AB44};
      vecs[6] = '{"m1 hi wr",     1'b1, 1'b1, 32'h18, 32'h1234_5678, 4'hC, 32'h0};
      vecs[7] = '{"m1 rd 0x18",   1'b1, 1'b0, 32'h18, 32'h0,         4'h0, 32'h1234_AAAA};

      iwRst = 1'b1;
      driveMaster(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      driveMaster(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      bM0Valid = 1'b0; bM0Write = 1'b0; bM0Addr = 32'h0; bM0WData = 32'h0; bM0Wstrb = 4'h0;
      bM1Valid = 1'b0; bM1Write = 1'b0; bM1Addr = 32'h0; bM1WData = 32'h0; bM1Wstrb = 4'h0;

      resetDut();

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
      end

      // Simultaneous reads: M0 first, then M1, each response on its own bus
      resetDut();
      driveMaster(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      driveMaster(1'b1, 1'b1, 1'b0, 32'h18, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("tie first ready", {aM1Ready, aM0Ready}, 2'b01);
      checkOutput("tie first raddr", aSReadAddr, 32'h10);
      driveMaster(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      checkOutput("tie m0 rvalid", {aM1RValid, aM0RValid}, 2'b01);
      checkOutput("tie m0 rdata", aM0RData, 32'hDEAD_BEEF);
      @(negedge clk);
      checkOutput("tie second ready", {aM1Ready, aM0Ready}, 2'b10);
      checkOutput("tie second raddr", aSReadAddr, 32'h18);
      driveMaster(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);
      @(negedge clk);
      checkOutput("tie m1 rvalid", {aM1RValid, aM0RValid}, 2'b10);
      checkOutput("tie m1 rdata", aM1RData, 32'h1234_AAAA);
      checkOutput("tie m0 rdata held", aM0RData, 32'hDEAD_BEEF);

      // Continuous writes from both masters must alternate grants
      resetDut();
      m0Grants = 0;
      m1Grants = 0;
      driveMaster(1'b0, 1'b1, 1'b1, 32'h20, 32'hAAAA_0000, 4'hF);
      driveMaster(1'b1, 1'b1, 1'b1, 32'h24, 32'hBBBB_0000, 4'hF);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k % 2 == 1) expReady = 2'b00;
         else if ((k / 2) % 2 == 0) expReady = 2'b01;
         else expReady = 2'b10;
         checkOutput($sformatf("fair cycle %0d ready", k), {aM1Ready, aM0Ready}, expReady);
         if (aM0Ready) m0Grants++;
         if (aM1Ready) m1Grants++;
      end
      driveMaster(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      driveMaster(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      checkOutput("fair m0 grants", m0Grants, 4);
      checkOutput("fair m1 grants", m1Grants, 4);

      // Reset during RWAIT of an M0 read abandons it
      @(negedge clk);
      driveMaster(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput("abort ready", {aM1Ready, aM0Ready}, 2'b01);
      driveMaster(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      iwRst = 1'b1;
      @(negedge clk);
      checkAllZero("abort outputs zero");
      iwRst = 1'b0;
      expRData[0] = 32'h0;
      expRData[1] = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("abort no rvalid", {aM1RValid, aM0RValid, aM1Ready, aM0Ready}, 4'h0);
      end
      applyStimulus('{"post abort m1 rd", 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, 32'h1122_AB44});

      // Latency 3 instance: M1 read holds the read address through RWAIT
      bM1Valid = 1'b1;
      bM1Addr  = 32'h40;
      @(negedge clk);
      checkOutput("lat3 ready", {bM1Ready, bM0Ready}, 2'b10);
      checkOutput("lat3 raddr", bSReadAddr, 32'h40);
      bM1Valid = 1'b0;
      bM1Addr  = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput($sformatf("lat3 rwait %0d raddr", k), bSReadAddr, 32'h40);
         checkOutput($sformatf("lat3 rwait %0d rvalid", k), {bM1RValid, bM0RValid}, 2'b00);
      end
      @(negedge clk);
      checkOutput("lat3 rdone rvalid", {bM1RValid, bM0RValid}, 2'b00);
      @(negedge clk);
      checkOutput("lat3 rvalid", {bM1RValid, bM0RValid}, 2'b10);
      checkOutput("lat3 rdata", bM1RData, 32'h0040_C0DE);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
